// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sweep sequencer.
// Holds the FSM state enum, default geometry and the binary-to-Gray mapping.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DWELL = 10;

    // Widths up to 32 bits; callers zero-extend and truncate back to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/b2g_conv.sv
// Combinational WIDTH-bit binary-to-Gray converter.
// Sits on the next-code path so the Gray register loads alongside the binary register.
module b2g_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Handshaked sequencer that sweeps a WIDTH-bit code through all 2^WIDTH values,
// holding each for DWELL cycles and presenting a registered, aligned binary/Gray pair.
module gray_sweep_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int                CW       = $clog2(DWELL + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0]  ALL_ONES = '1;

    state_e           state_q;
    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [CW-1:0]    cnt_q;
    logic             dir_q;
    logic             valid_q, busy_q, done_q;

    logic             dwell_end;
    logic             last_code;
    logic             accept;

    always_comb begin
        dwell_end = (cnt_q == CNT_LAST);
        last_code = dir_q ? (bin_q == '0) : (bin_q == ALL_ONES);
        accept    = (state_q == IDLE) && start && !abort;
        bin_d     = bin_q;
        if (accept) begin
            bin_d = dir ? ALL_ONES : '0;
        end else if ((state_q == RUN) && !abort && !pause && dwell_end && !last_code) begin
            bin_d = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
        end
    end

    // Gray is derived from the next binary value so both registers load on the same edge.
    b2g_conv #(.WIDTH(WIDTH)) u_b2g (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        dir_q   <= dir;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!pause) begin
                        if (dwell_end) begin
                            cnt_q <= '0;
                            if (last_code) begin
                                state_q <= DONE;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // Single-cycle state; abort here lands in IDLE just the same.
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Scoreboard bench for gray_sweep_ctrl: stimulus queues hand-computed codes,
// a negedge monitor pops and compares whenever the DUT shows valid or done.
module tb_gray_sweep_ctrl;
    import gray_pkg::*;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic       d;
    } exp_t;

    localparam logic [3:0] GRAY4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, dir = 1'b0, pause = 1'b0, abort = 1'b0;
    logic       start1 = 1'b0, zero1 = 1'b0;
    logic [3:0] bin, gray, bin1, gray1;
    logic       valid, busy, done, valid1, busy1, done1;

    int   n_vec = 0, n_miss = 0, cyc = 0, t_acc = 0;
    exp_t q[$];

    gray_sweep_ctrl #(.WIDTH(4), .DWELL(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .pause(pause), .abort(abort),
        .bin_out(bin), .gray_out(gray), .valid(valid), .busy(busy), .done(done)
    );

    gray_sweep_ctrl #(.WIDTH(4), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dir(zero1), .pause(zero1), .abort(zero1),
        .bin_out(bin1), .gray_out(gray1), .valid(valid1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (valid || done)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected: got bin=%h gray=%h valid=%b done=%b expected no output",
                         bin, gray, valid, done);
            end else begin
                e = q.pop_front();
                if (e.d)
                    check("sb_done", {valid, busy, done}, 3'b011);
                else
                    check("sb_code", {bin, gray, valid, busy, done}, {e.b, e.g, 3'b110});
            end
        end
    end

    task automatic push_code(input int code, input int n);
        exp_t e;
        e.b = 4'(code);
        e.g = GRAY4[code];
        e.d = 1'b0;
        repeat (n) q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '0;
        e.d = 1'b1;
        q.push_back(e);
    endtask

    task automatic push_sweep(input bit down, input int pcode, input int plen);
        for (int k = 0; k < 16; k++) begin
            int c;
            c = down ? 15 - k : k;
            push_code(c, 10 + ((c == pcode) ? plen : 0));
        end
        push_done();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit d, input bit hold);
        dir   = d;
        start = 1'b1;
        tick();
        t_acc = cyc;
        if (!hold) start = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge.
    task automatic wait_done(input string name, input int exp_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no done within 400 cycles expected done in cycle %0d",
                     name, exp_cyc);
        end else begin
            check({name, "_done_cycle"}, cyc - t_acc + 1, exp_cyc);
        end
        @(negedge clk);
        check({name, "_idle_after"}, {valid, busy, done}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_outputs", {bin, gray, valid, busy, done}, 11'h0);
        check("reset_outputs_dwell1", {bin1, gray1, valid1, busy1, done1}, 11'h0);
        rst_n = 1'b1;
        tick();

        push_sweep(1'b0, -1, 0);
        go(1'b0, 1'b0);
        wait_done("up", 161);
        check("up_sb_empty", q.size(), 0);

        push_sweep(1'b1, -1, 0);
        go(1'b1, 1'b0);
        repeat (40) tick();
        dir = 1'b0;
        wait_done("down", 161);
        check("down_sb_empty", q.size(), 0);

        push_sweep(1'b0, 5, 5);
        go(1'b0, 1'b0);
        repeat (52) tick();
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
        wait_done("pause", 166);
        check("pause_sb_empty", q.size(), 0);

        for (int c = 0; c < 8; c++) push_code(c, 10);
        push_code(8, 4);
        go(1'b0, 1'b0);
        repeat (83) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_drop", {valid, busy, done}, 3'b000);
        repeat (20) tick();
        check("abort_sb_empty", q.size(), 0);
        push_sweep(1'b0, -1, 0);
        go(1'b0, 1'b0);
        wait_done("abort_restart", 161);
        check("abort_restart_sb_empty", q.size(), 0);

        push_sweep(1'b0, -1, 0);
        go(1'b0, 1'b0);
        repeat (30) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bin, gray, valid, busy, done}, 11'h0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_sweep(1'b0, -1, 0);
        go(1'b0, 1'b0);
        wait_done("post_reset", 161);
        check("post_reset_sb_empty", q.size(), 0);

        push_sweep(1'b0, -1, 0);
        push_sweep(1'b0, -1, 0);
        go(1'b0, 1'b1);
        wait_done("hold1", 161);
        @(negedge clk);
        check("hold_restart_cycle", {cyc - t_acc + 1, valid, bin}, {32'd163, 1'b1, 4'h0});
        start = 1'b0;
        wait_done("hold2", 323);
        check("hold_sb_empty", q.size(), 0);

        start = 1'b1;
        abort = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("start_abort_idle", {valid, busy, done}, 3'b000);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("start_abort_sb_empty", q.size(), 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("dwell1_code", {bin1, gray1, valid1, busy1, done1}, {4'(k), GRAY4[k], 3'b110});
        end
        @(negedge clk);
        check("dwell1_done_cycle17", {valid1, busy1, done1}, 3'b011);
        @(negedge clk);
        check("dwell1_idle_after", {valid1, busy1, done1}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
